// File: rtl/cdiv.sv
`timescale 1ns/1ps
// cdiv: iterative complex divider (pr+j.pi)/(br+j.bi) = ar+j.ai.
// It uses a shared-denominator restoring division engine with valid/ready handshakes.
module cdiv #(
    parameter int AWIDTH = 8,
    parameter int BWIDTH = 9,
    localparam int PWIDTH = AWIDTH + BWIDTH + 1,
    localparam int MWIDTH = PWIDTH + BWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PWIDTH-1:0] pr,
    input  logic [PWIDTH-1:0] pi,
    input  logic [BWIDTH-1:0] br,
    input  logic [BWIDTH-1:0] bi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] ar,
    output logic [AWIDTH-1:0] ai,
    output logic              ovf,
    output logic              dbz
);
    localparam int DWIDTH = 2 * BWIDTH;
    localparam int NWIDTH = MWIDTH + 1;
    localparam int CWIDTH = $clog2(MWIDTH);
    localparam logic [MWIDTH-1:0] QPOS = MWIDTH'(2 ** (AWIDTH - 1) - 1);
    localparam logic [MWIDTH-1:0] QNEG = MWIDTH'(2 ** (AWIDTH - 1));
    localparam logic [AWIDTH-1:0] APOS = {1'b0, {(AWIDTH - 1){1'b1}}};
    localparam logic [AWIDTH-1:0] ANEG = {1'b1, {(AWIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MULT, ABS, DIV, SAT, DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [PWIDTH-1:0]  pr_q, pr_d, pi_q, pi_d;
    logic signed [BWIDTH-1:0]  br_q, br_d, bi_q, bi_d;
    logic signed [NWIDTH-1:0]  nr_q, nr_d, ni_q, ni_d;
    logic [DWIDTH-1:0]         den_q, den_d;
    logic                      sr_q, sr_d, si_q, si_d;
    logic [MWIDTH-1:0]         qr_q, qr_d, qi_q, qi_d;
    logic [DWIDTH-1:0]         rr_q, rr_d, ri_q, ri_d;
    logic [CWIDTH-1:0]         cnt_q, cnt_d;
    logic [AWIDTH-1:0]         ar_q, ar_d, ai_q, ai_d;
    logic                      ovf_q, ovf_d, dbz_q, dbz_d;

    // Each magnitude register shifts its numerator out MSB-first while quotient bits shift in.
    logic [DWIDTH:0]   shr, shi;
    logic              ger, gei, ovr, ovi;
    logic [AWIDTH-1:0] sat_r, sat_i;

    assign shr = {rr_q, qr_q[MWIDTH-1]};
    assign shi = {ri_q, qi_q[MWIDTH-1]};
    assign ger = shr >= {1'b0, den_q};
    assign gei = shi >= {1'b0, den_q};
    assign ovr = sr_q ? (qr_q > QNEG) : (qr_q > QPOS);
    assign ovi = si_q ? (qi_q > QNEG) : (qi_q > QPOS);
    assign sat_r = ovr ? (sr_q ? ANEG : APOS) : (sr_q ? -qr_q[AWIDTH-1:0] : qr_q[AWIDTH-1:0]);
    assign sat_i = ovi ? (si_q ? ANEG : APOS) : (si_q ? -qi_q[AWIDTH-1:0] : qi_q[AWIDTH-1:0]);

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign ar        = ar_q;
    assign ai        = ai_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        pi_d    = pi_q;
        br_d    = br_q;
        bi_d    = bi_q;
        nr_d    = nr_q;
        ni_d    = ni_q;
        den_d   = den_q;
        sr_d    = sr_q;
        si_d    = si_q;
        qr_d    = qr_q;
        qi_d    = qi_q;
        rr_d    = rr_q;
        ri_d    = ri_q;
        cnt_d   = cnt_q;
        ar_d    = ar_q;
        ai_d    = ai_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                pr_d    = pr;
                pi_d    = pi;
                br_d    = br;
                bi_d    = bi;
                state_d = MULT;
            end
            MULT: begin
                nr_d    = NWIDTH'(pr_q) * NWIDTH'(br_q) + NWIDTH'(pi_q) * NWIDTH'(bi_q);
                ni_d    = NWIDTH'(pi_q) * NWIDTH'(br_q) - NWIDTH'(pr_q) * NWIDTH'(bi_q);
                den_d   = DWIDTH'(br_q) * DWIDTH'(br_q) + DWIDTH'(bi_q) * DWIDTH'(bi_q);
                state_d = ABS;
            end
            ABS: begin
                sr_d    = nr_q[MWIDTH];
                si_d    = ni_q[MWIDTH];
                qr_d    = nr_q[MWIDTH] ? MWIDTH'(-nr_q) : nr_q[MWIDTH-1:0];
                qi_d    = ni_q[MWIDTH] ? MWIDTH'(-ni_q) : ni_q[MWIDTH-1:0];
                rr_d    = '0;
                ri_d    = '0;
                cnt_d   = '0;
                dbz_d   = den_q == '0;
                ar_d    = '0;
                ai_d    = '0;
                ovf_d   = 1'b0;
                state_d = den_q == '0 ? DONE : DIV;
            end
            DIV: begin
                rr_d    = DWIDTH'(ger ? shr - {1'b0, den_q} : shr);
                ri_d    = DWIDTH'(gei ? shi - {1'b0, den_q} : shi);
                qr_d    = {qr_q[MWIDTH-2:0], ger};
                qi_d    = {qi_q[MWIDTH-2:0], gei};
                cnt_d   = cnt_q + CWIDTH'(1);
                state_d = cnt_q == CWIDTH'(MWIDTH - 1) ? SAT : DIV;
            end
            SAT: begin
                ar_d    = sat_r;
                ai_d    = sat_i;
                ovf_d   = ovr | ovi;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: if (out_ready) begin
                ar_d    = '0;
                ai_d    = '0;
                ovf_d   = 1'b0;
                dbz_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pr_q    <= '0;
            pi_q    <= '0;
            br_q    <= '0;
            bi_q    <= '0;
            nr_q    <= '0;
            ni_q    <= '0;
            den_q   <= '0;
            sr_q    <= 1'b0;
            si_q    <= 1'b0;
            qr_q    <= '0;
            qi_q    <= '0;
            rr_q    <= '0;
            ri_q    <= '0;
            cnt_q   <= '0;
            ar_q    <= '0;
            ai_q    <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            pi_q    <= pi_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
            nr_q    <= nr_d;
            ni_q    <= ni_d;
            den_q   <= den_d;
            sr_q    <= sr_d;
            si_q    <= si_d;
            qr_q    <= qr_d;
            qi_q    <= qi_d;
            rr_q    <= rr_d;
            ri_q    <= ri_d;
            cnt_q   <= cnt_d;
            ar_q    <= ar_d;
            ai_q    <= ai_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule
